serial_addsub_8bit: RTL and testbench

Bit-serial, multi-cycle counterpart of the team's combinational 8-bit add/subtract instruction datapath. It accepts one operand pair and an OP select through a start/done handshake. It computes A+B or A-B LSB-first, one bit per clock, through a single full-adder cell. It returns the registered result plus C/V/Z status flags to the instruction sequencer, so small-area builds can replace the 8-cell ripple array.

---
 rtl/alu_pkg.sv | 16 +
 rtl/full_adder_bit.sv | 15 +
 rtl/serial_addsub_8bit.sv | 128 ++++++++++++
 tb/tb_serial_addsub_8bit.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the add/subtract datapaths: FSM states, OP encoding
// and the default operand width.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_bit.sv
// One full-adder cell, identical to a single stage of the parallel ripple adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_addsub_8bit.sv
// Bit-serial add/subtract: one result bit per clock through a single full-adder
// cell, start/done handshake, registered S/C/V/Z results.
module serial_addsub_8bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             OP,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             Z
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             cy;
    logic             cmsb;
    logic             fa_s;
    logic             fa_c;
    logic             load;
    logic             last;

    full_adder_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (cy),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign last = (count == CW'(WIDTH - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_n = FIN;
                end
            end
            FIN: begin
                if (START) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state != IDLE);
    end

    // Subtract is A + ~B + 1: B is inverted on load and the carry seeded with OP.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            cy    <= 1'b0;
            cmsb  <= 1'b0;
            DONE  <= 1'b0;
            S     <= '0;
            C     <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (state == FIN) begin
                S    <= r_sh;
                C    <= cy;
                V    <= cy ^ cmsb;
                Z    <= (r_sh == '0);
                DONE <= 1'b1;
            end
            if (load) begin
                a_sh  <= A;
                b_sh  <= B ^ {WIDTH{OP}};
                cy    <= (OP == OP_SUB);
                count <= '0;
            end else if (state == SHIFT) begin
                r_sh  <= {fa_s, r_sh[WIDTH-1:1]};
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                cy    <= fa_c;
                count <= count + 1'b1;
                // carry into the MSB cell, needed for the overflow flag
                if (last) begin
                    cmsb <= cy;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_8bit.sv
// Self-checking bench for serial_addsub_8bit: expected results are queued when
// an operation is started and popped when DONE is observed.
module tb_serial_addsub_8bit;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
        logic       z;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       OP = OP_ADD;
    logic       START = 1'b0;
    logic       BUSY;
    logic       DONE;
    logic [7:0] S;
    logic       C;
    logic       V;
    logic       Z;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t last_exp = '0;

    serial_addsub_8bit #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .A     (A),
        .B     (B),
        .OP    (OP),
        .START (START),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .S     (S),
        .C     (C),
        .V     (V),
        .Z     (Z)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic op);
        exp_t e;
        int   sa;
        int   sbv;
        int   r;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (op == OP_SUB) begin
            e.s = a - b;
            e.c = (a >= b);
            r   = sa - sbv;
        end else begin
            e.s = a + b;
            e.c = ((int'(a) + int'(b)) > 255);
            r   = sa + sbv;
        end
        e.v = (r > 127) || (r < -128);
        e.z = (e.s == 8'h00);
        return e;
    endfunction

    // Drives START for the acceptance edge and returns edges from acceptance to DONE.
    task automatic wait_done(output int lat, output int busy_n, output bit ok);
        lat    = 0;
        busy_n = 0;
        ok     = 1'b0;
        for (int i = 0; i <= 25; i++) begin
            @(posedge CLK);
            #1;
            if (i == 0) START = 1'b0;
            if (BUSY) busy_n++;
            if (DONE) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic op, input exp_t e);
        A     = a;
        B     = b;
        OP    = op;
        START = 1'b1;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({BUSY, DONE, S, C, V, Z} !== 13'b0) begin
            errors++;
            $display("FAIL reset_hold: got busy=%b done=%b s=%h c=%b v=%b z=%b, need all 0", BUSY, DONE, S, C, V, Z);
        end
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({BUSY, DONE, S, C, V, Z} !== 13'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b s=%h c=%b v=%b z=%b, need all 0", BUSY, DONE, S, C, V, Z);
        end
    endtask

    task automatic test_basic();
        int   lat;
        int   busy_n;
        bit   ok;
        exp_t e;
        start_op(8'h05, 8'h03, OP_ADD, '{s: 8'h08, c: 1'b0, v: 1'b0, z: 1'b0});
        wait_done(lat, busy_n, ok);
        checks++;
        if (!ok || lat !== 9) begin
            errors++;
            $display("FAIL basic_latency: got %0d (done seen=%b), need 9", lat, ok);
        end
        checks++;
        if (busy_n !== 9) begin
            errors++;
            $display("FAIL basic_busy: got %0d busy cycles, need 9", busy_n);
        end
        if (ok) begin
            e = sb.pop_front();
            last_exp = e;
            checks++;
            if ({S, C, V, Z} !== e) begin
                errors++;
                $display("FAIL basic_result: got s=%h c=%b v=%b z=%b, need s=%h c=%b v=%b z=%b", S, C, V, Z, e.s, e.c, e.v, e.z);
            end
        end else begin
            void'(sb.pop_front());
        end
    endtask

    task automatic test_flags();
        logic [7:0] ta[5] = '{8'h7F, 8'hFF, 8'h10, 8'h00, 8'h80};
        logic [7:0] tb_[5] = '{8'h01, 8'h01, 8'h10, 8'h01, 8'h01};
        logic       to[5] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB};
        exp_t       te[5] = '{'{8'h80, 1'b0, 1'b1, 1'b0},
                              '{8'h00, 1'b1, 1'b0, 1'b1},
                              '{8'h00, 1'b1, 1'b0, 1'b1},
                              '{8'hFF, 1'b0, 1'b0, 1'b0},
                              '{8'h7F, 1'b1, 1'b1, 1'b0}};
        int         lat;
        int         busy_n;
        bit         ok;
        exp_t       e;
        for (int i = 0; i < 5; i++) begin
            start_op(ta[i], tb_[i], to[i], te[i]);
            wait_done(lat, busy_n, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || {S, C, V, Z} !== e) begin
                errors++;
                $display("FAIL flags_%0d: got done=%b s=%h c=%b v=%b z=%b, need s=%h c=%b v=%b z=%b", i, ok, S, C, V, Z, e.s, e.c, e.v, e.z);
            end
            last_exp = e;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int   hold_err;
        int   lat;
        int   busy_n;
        bit   ok;
        exp_t e;
        start_op(8'h22, 8'h11, OP_ADD, '{s: 8'h33, c: 1'b0, v: 1'b0, z: 1'b0});
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        A = 8'h01; B = 8'h01; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        A = 8'hAA; B = 8'h55; OP = OP_SUB;
        repeat (4) begin @(posedge CLK); #1; end
        checks++;
        if (S !== last_exp.s || DONE !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold_prev: got s=%h done=%b, need s=%h done=0", S, DONE, last_exp.s);
        end
        @(posedge CLK);
        #1;
        A = 8'h01; B = 8'h01; OP = OP_ADD; START = 1'b1;
        sb.push_back('{s: 8'h02, c: 1'b0, v: 1'b0, z: 1'b0});
        @(posedge CLK);
        #1;
        START = 1'b0;
        e = sb.pop_front();
        checks++;
        if (DONE !== 1'b1 || {S, C, V, Z} !== e) begin
            errors++;
            $display("FAIL b2b_first: got done=%b s=%h c=%b v=%b z=%b, need done=1 s=%h", DONE, S, C, V, Z, e.s);
        end
        hold_err = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            if (DONE !== 1'b0 || S !== 8'h33 || BUSY !== 1'b1) hold_err++;
        end
        checks++;
        if (hold_err !== 0) begin
            errors++;
            $display("FAIL b2b_stable: got %0d bad cycles, need 0", hold_err);
        end
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        last_exp = e;
        checks++;
        if (DONE !== 1'b1 || {S, C, V, Z} !== e) begin
            errors++;
            $display("FAIL b2b_second: got done=%b s=%h c=%b v=%b z=%b, need done=1 s=%h", DONE, S, C, V, Z, e.s);
        end
    endtask

    task automatic test_reset_midop();
        int   seen;
        int   lat;
        int   busy_n;
        bit   ok;
        exp_t e;
        @(posedge CLK);
        #1;
        A = 8'h55; B = 8'h22; OP = OP_ADD; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({BUSY, DONE, S, C, V, Z} !== 13'b0) begin
            errors++;
            $display("FAIL midop_reset: got busy=%b done=%b s=%h c=%b v=%b z=%b, need all 0", BUSY, DONE, S, C, V, Z);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midop_no_done: got %0d active cycles, need 0", seen);
        end
        start_op(8'h0A, 8'h03, OP_SUB, '{s: 8'h07, c: 1'b1, v: 1'b0, z: 1'b0});
        wait_done(lat, busy_n, ok);
        e = sb.pop_front();
        last_exp = e;
        checks++;
        if (!ok || {S, C, V, Z} !== e) begin
            errors++;
            $display("FAIL midop_recover: got done=%b s=%h c=%b v=%b z=%b, need s=%h c=%b", ok, S, C, V, Z, e.s, e.c);
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        int         lat;
        int         busy_n;
        bit         ok;
        exp_t       e;
        for (int n = 0; n < 1000; n++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 1'($urandom);
            if (n < 4) begin
                a = (n[0]) ? 8'hFF : 8'h00;
                b = (n[1]) ? 8'hFF : 8'h00;
            end
            start_op(a, b, op, model(a, b, op));
            wait_done(lat, busy_n, ok);
            checks++;
            if (!ok || sb.size() == 0) begin
                errors++;
                $display("FAIL rand_%0d_timeout: done=%b queued=%0d, need done=1", n, ok, sb.size());
                if (sb.size() != 0) void'(sb.pop_front());
            end else begin
                e = sb.pop_front();
                if ({S, C, V, Z} !== e || lat !== 9) begin
                    errors++;
                    $display("FAIL rand_%0d: %h %s %h got s=%h c=%b v=%b z=%b lat=%0d, need s=%h c=%b v=%b z=%b lat=9",
                             n, a, op ? "-" : "+", b, S, C, V, Z, lat, e.s, e.c, e.v, e.z);
                end
            end
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        test_reset();
        @(posedge CLK);
        #1;
        test_basic();
        test_flags();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
